// File: rtl/nn_udiv_13ns_5ns_seq.sv
// Sequential unsigned 13/5 restoring divider; NN_UDIV_DBZ_EARLY_EN short-cuts divide-by-zero.
// Latency: ap_done 14 enabled edges after start (1 edge for early divide-by-zero).
// Backpressure: none; ap_start is ignored while busy and ce low freezes all state.
module nn_udiv_13ns_5ns_seq #(
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 13
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz
);

`ifdef NN_UDIV_DBZ_EARLY_EN
  localparam bit DBZ_EARLY = 1'b1;
`else
  localparam bit DBZ_EARLY = 1'b0;
`endif

  localparam int CNT_W = $clog2(din0_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  // dividend bits leave at the MSB while quotient bits enter at the LSB
  logic [din0_WIDTH-1:0] dvd;
  logic [din1_WIDTH-1:0] dsr;
  logic [din1_WIDTH:0]   prem;
  logic                  zdiv;

  logic [din1_WIDTH:0]   pr_shift;
  logic [din1_WIDTH:0]   pr_next;
  logic                  q_bit;

  always_comb begin
    pr_shift = {prem[din1_WIDTH-1:0], dvd[din0_WIDTH-1]};
    q_bit    = (pr_shift >= {1'b0, dsr});
    pr_next  = q_bit ? (pr_shift - {1'b0, dsr}) : pr_shift;
  end

  assign ap_idle = (state == IDLE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ap_start) begin
          if (DBZ_EARLY && (din1 == '0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        if (cnt == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt     <= '0;
      dvd     <= '0;
      dsr     <= '0;
      prem    <= '0;
      zdiv    <= 1'b0;
      quot    <= '0;
      rem     <= '0;
      dbz     <= 1'b0;
      ap_done <= 1'b0;
    end else if (ce) begin
      // registered so the pulse coincides with the updated results
      ap_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (ap_start) begin
            dvd  <= din0;
            dsr  <= din1;
            prem <= '0;
            cnt  <= '0;
            zdiv <= (din1 == '0);
          end
        end
        CALC: begin
          dvd  <= {dvd[din0_WIDTH-2:0], q_bit};
          prem <= pr_next;
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          quot <= zdiv ? '1 : dout_WIDTH'(dvd);
          rem  <= zdiv ? '0 : prem[din1_WIDTH-1:0];
          dbz  <= DBZ_EARLY & zdiv;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_udiv_13ns_5ns_seq.sv
// Directed bench for nn_udiv_13ns_5ns_seq; expected results queued at issue, checked by a monitor on ap_done.
module tb_nn_udiv_13ns_5ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        ce = 1'b1;
  logic        ap_start = 1'b0;
  logic [12:0] din0 = '0;
  logic [4:0]  din1 = '0;
  logic        ap_idle, ap_done, dbz;
  logic [12:0] quot;
  logic [4:0]  rem;

  nn_udiv_13ns_5ns_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .ap_start(ap_start),
    .din0(din0), .din1(din1), .ap_idle(ap_idle), .ap_done(ap_done),
    .quot(quot), .rem(rem), .dbz(dbz)
  );

  always #5 ap_clk = ~ap_clk;

`ifdef NN_UDIV_DBZ_EARLY_EN
  localparam int  DBZ_LAT = 1;
  localparam bit  DBZ_FLAG = 1'b1;
`else
  localparam int  DBZ_LAT = 14;
  localparam bit  DBZ_FLAG = 1'b0;
`endif

  typedef struct {
    logic [12:0] q;
    logic [4:0]  r;
    logic        z;
    int          t;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [12:0] last_q = '0;
  logic [4:0]  last_r = '0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: every ap_done consumes one expected entry
  always @(negedge ap_clk) begin
    if (ap_done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'(-1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", 32'(quot), 32'(e.q));
        chk("rem", 32'(rem), 32'(e.r));
        chk("dbz", 32'(dbz), 32'(e.z));
        chk("done_edge", 32'(cyc), 32'(e.t));
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  // leaves the caller at the negedge right after the start-sampling edge
  task automatic start_op(input int a, input int b, input int lat,
                          input int q, input int r, input bit z);
    exp_t e;
    @(negedge ap_clk);
    chk("hold_quot", 32'(quot), 32'(last_q));
    chk("hold_rem", 32'(rem), 32'(last_r));
    ap_start = 1'b1;
    din0 = 13'(a);
    din1 = 5'(b);
    e.q = 13'(q);
    e.r = 5'(r);
    e.z = z;
    e.t = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge ap_clk);
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int n_before);
    int i;
    for (i = 0; i < 60 && done_cnt == n_before; i++) @(negedge ap_clk);
    if (done_cnt == n_before) begin
      chk("done_timeout", 32'(done_cnt), 32'(n_before + 1));
      sb.delete();
    end
  endtask

  task automatic run_op(input int a, input int b, input int lat,
                        input int q, input int r, input bit z);
    int n;
    n = done_cnt;
    start_op(a, b, lat, q, r, z);
    wait_done(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 ap_rst = 1'b1;
    #1;
    chk("rst_quot", 32'(quot), 0);
    chk("rst_rem", 32'(rem), 0);
    chk("rst_dbz", 32'(dbz), 0);
    chk("rst_done", 32'(ap_done), 0);
    chk("rst_idle", 32'(ap_idle), 1);
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;

    run_op(100, 7, 14, 14, 2, 1'b0);
    run_op(8191, 31, 14, 264, 7, 1'b0);
    run_op(0, 5, 14, 0, 0, 1'b0);
    run_op(5, 0, DBZ_LAT, 13'h1FFF, 0, DBZ_FLAG);
    run_op(100, 7, 14, 14, 2, 1'b0);

    // second start mid-calculation must be dropped
    n = done_cnt;
    start_op(1000, 9, 14, 111, 1, 1'b0);
    repeat (4) @(negedge ap_clk);
    chk("busy_idle_a", 32'(ap_idle), 0);
    ap_start = 1'b1;
    din0 = 13'd50;
    din1 = 5'd3;
    @(negedge ap_clk);
    ap_start = 1'b0;
    chk("busy_idle_b", 32'(ap_idle), 0);
    @(negedge ap_clk);
    chk("busy_idle_c", 32'(ap_idle), 0);
    wait_done(n);
    repeat (20) @(negedge ap_clk);
    chk("no_queued_op", 32'(done_cnt), 32'(n + 1));

    // clock enable stall of three edges
    n = done_cnt;
    start_op(1234, 13, 17, 94, 12, 1'b0);
    repeat (3) @(negedge ap_clk);
    ce = 1'b0;
    repeat (3) @(negedge ap_clk);
    ce = 1'b1;
    wait_done(n);

    // asynchronous reset after six steps
    n = done_cnt;
    @(negedge ap_clk);
    ap_start = 1'b1;
    din0 = 13'd100;
    din1 = 5'd7;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (6) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    chk("arst_quot", 32'(quot), 0);
    chk("arst_rem", 32'(rem), 0);
    chk("arst_idle", 32'(ap_idle), 1);
    chk("arst_done", 32'(ap_done), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    last_q = '0;
    last_r = '0;
    repeat (20) @(negedge ap_clk);
    chk("abort_no_done", 32'(done_cnt), 32'(n));
    run_op(100, 7, 14, 14, 2, 1'b0);

    repeat (3) @(negedge ap_clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/nn_udiv_13ns_5ns_seq.md
NN_UDIV_13NS_5NS_SEQ -- requirements
Module: nn_udiv_13ns_5ns_seq

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 13, dividend width.
REQ-002 SHALL have parameter din1_WIDTH, default 5, divisor width.
REQ-003 SHALL have parameter dout_WIDTH, default 13, quotient width; remainder width equals din1_WIDTH.
REQ-004 SHALL have port ap_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port ap_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ce  input  1  clock enable; low freezes all state.
REQ-007 SHALL have port ap_start  input  1  request; sampled only in IDLE with ce high.
REQ-008 SHALL have port din0  input  din0_WIDTH  unsigned dividend, sampled with ap_start.
REQ-009 SHALL have port din1  input  din1_WIDTH  unsigned divisor, sampled with ap_start.
REQ-010 SHALL have port ap_idle  output  1  high while in IDLE.
REQ-011 SHALL have port ap_done  output  1  one-cycle pulse, results valid.
REQ-012 SHALL have port quot  output  dout_WIDTH  registered quotient.
REQ-013 SHALL have port rem  output  din1_WIDTH  registered remainder.
REQ-014 SHALL have port dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-015 SHALL implement a three-state FSM IDLE, CALC, DONE.
REQ-016 SHALL, in IDLE with ap_start=1 and ce=1, latch din0/din1, clear the partial remainder and iteration counter, and go to CALC on that edge.
REQ-017 SHALL, in CALC, perform one restoring-division step per enabled edge: shift the next dividend bit (MSB first) into a din1_WIDTH+1-bit partial remainder, subtract the divisor if the result is non-negative, and shift the resulting quotient bit in.
REQ-018 SHALL leave CALC for DONE after exactly din0_WIDTH (13) enabled steps, counted by a 4-bit counter.
REQ-019 SHALL, in DONE, drive ap_done=1 for one cycle, update quot/rem/dbz, and return to IDLE on the next enabled edge.
REQ-020 SHALL give a latency of 14 enabled edges from the start-sampling edge to ap_done high; initiation interval is 15 cycles.
REQ-021 SHALL ignore ap_start in CALC and DONE; no queuing.
REQ-022 SHALL hold quot, rem, and dbz stable between ap_done pulses.
REQ-023 SHALL guarantee quot*din1 + rem = din0 and rem < din1 for every din1 != 0.
REQ-024 SHALL, when din1 = 0, report quot = all ones (0x1FFF) and rem = 0.
REQ-025 SHALL, with ce low, stall all state, including counter, FSM, and ap_done level.

Reset
REQ-026 SHALL, on ap_rst high, immediately set state=IDLE, counter=0, quot=0, rem=0, dbz=0, ap_done=0, ap_idle=1, independent of ce and ap_clk.
REQ-027 SHALL abort any in-flight operation on reset without producing ap_done.

Configuration
REQ-028 SHALL use macro NN_UDIV_DBZ_EARLY_EN.
REQ-029 SHALL, with NN_UDIV_DBZ_EARLY_EN defined, route din1 = 0 at start directly from IDLE to DONE, giving ap_done 1 edge after start with quot=0x1FFF, rem=0, dbz=1.
REQ-030 SHALL, without NN_UDIV_DBZ_EARLY_EN, run din1 = 0 through the full 13 CALC steps with forced outputs quot=0x1FFF, rem=0, and hold dbz at 0.

Verification
REQ-031 Bench SHALL check din0=100, din1=7, start -> ap_done 14 edges later, quot=14, rem=2.
REQ-032 Bench SHALL check din0=8191, din1=31 -> quot=264, rem=7; din0=0, din1=5 -> quot=0, rem=0.
REQ-033 Bench SHALL check din0=5, din1=0 -> quot=0x1FFF, rem=0; with the macro, ap_done after 1 edge and dbz=1; without it, ap_done after 14 edges and dbz=0.
REQ-034 Bench SHALL check ap_start pulsed again mid-CALC with new operands -> ignored; the first result is delivered unchanged and ap_idle=0 throughout.
REQ-035 Bench SHALL check ce held low 3 cycles mid-CALC -> ap_done delayed by exactly 3 cycles and result still correct.
REQ-036 Bench SHALL check ap_rst asserted asynchronously at step 6 -> outputs 0, ap_idle=1 immediately, and no ap_done; a new start (100/7) afterwards completes normally.
